// File: rtl/rr_prio_arbiter.sv
// Registered N-way arbiter with fixed-priority or round-robin selection,
// grant hold while the owner keeps requesting, and optional bounded hold time.
module rr_prio_arbiter #(
  parameter  int N        = 8,
  parameter  int MODE     = 1,
  parameter  int MAX_HOLD = 0,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [N-1:0]   gnt_r;
  logic [W-1:0]   gnt_idx_r;
  logic           gnt_vld_r;
  logic [W-1:0]   ptr_r;
  logic [HW-1:0]  hcnt_r;

  logic [N-1:0]   masked_s;
  logic           own_req_s;
  logic           any_req_s;
  logic           any_oth_s;
  logic           at_lim_s;
  logic [W-1:0]   win_all_s;
  logic [W-1:0]   win_oth_s;
  logic           grant_s;
  logic           clear_s;
  logic [W-1:0]   new_idx_s;

  // Fixed priority keeps the last (highest) hit; round-robin keeps the first hit from p.
  function automatic logic [W-1:0] pick_idx(input logic [N-1:0] c, input logic [W-1:0] p);
    logic [W-1:0] r;
    logic         found;
    logic [N-1:0] sh;
    int           j;
    r     = {W{1'b0}};
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (MODE == 0) begin
        j = N - 1 - off;
      end else begin
        j = (int'(p) + off) % N;
      end
      sh = c >> j;
      if (!found && sh[0]) begin
        r     = W'(j);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] k);
    return {{(N-1){1'b0}}, 1'b1} << k;
  endfunction

  function automatic logic [W-1:0] next_ptr(input logic [W-1:0] k);
    return (32'(k) == 32'(N - 1)) ? {W{1'b0}} : W'(32'(k) + 32'd1);
  endfunction

  assign masked_s  = req & ~gnt_r;
  assign own_req_s = |(req & gnt_r);
  assign any_req_s = |req;
  assign any_oth_s = |masked_s;
  assign win_all_s = pick_idx(req, ptr_r);
  assign win_oth_s = pick_idx(masked_s, ptr_r);

  // Hold-limit flag; never true when the hold time is unbounded.
  always_comb begin
    at_lim_s = 1'b0;
    if (MAX_HOLD != 0) begin
      at_lim_s = (hcnt_r == HW'(MAX_HOLD));
    end else begin
      at_lim_s = 1'b0;
    end
  end

  // Next-state decision: new grant, return to idle, or hold the current owner.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    clear_s     = 1'b0;
    new_idx_s   = win_all_s;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_s     = 1'b1;
          new_idx_s   = win_all_s;
          state_nxt_s = BUSY;
        end else begin
          clear_s     = 1'b1;
        end
      end
      BUSY: begin
        if (!own_req_s) begin
          if (any_oth_s) begin
            grant_s     = 1'b1;
            new_idx_s   = win_oth_s;
          end else begin
            clear_s     = 1'b1;
            state_nxt_s = IDLE;
          end
        end else if (at_lim_s && any_oth_s) begin
          grant_s   = 1'b1;
          new_idx_s = win_oth_s;
        end else begin
          grant_s = 1'b0;
        end
      end
      default: begin
        clear_s     = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbiter state, grant outputs, round-robin pointer and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt_r     <= {N{1'b0}};
      gnt_idx_r <= {W{1'b0}};
      gnt_vld_r <= 1'b0;
      ptr_r     <= {W{1'b0}};
      hcnt_r    <= {HW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        gnt_r     <= onehot(new_idx_s);
        gnt_idx_r <= new_idx_s;
        gnt_vld_r <= 1'b1;
        hcnt_r    <= HW'(1);
        if (MODE == 1) begin
          ptr_r <= next_ptr(new_idx_s);
        end else begin
          ptr_r <= {W{1'b0}};
        end
      end else if (clear_s) begin
        gnt_r     <= {N{1'b0}};
        gnt_idx_r <= {W{1'b0}};
        gnt_vld_r <= 1'b0;
        hcnt_r    <= {HW{1'b0}};
      end else if (MAX_HOLD != 0 && !at_lim_s) begin
        hcnt_r <= hcnt_r + HW'(1);
      end else begin
        hcnt_r <= hcnt_r;
      end
    end
  end

  assign gnt     = gnt_r;
  assign gnt_idx = gnt_idx_r;
  assign gnt_vld = gnt_vld_r;

endmodule
